// File: rtl/fpu_req_arbiter_if.sv
// Request/response bundle between two FPU requesters, the arbiter and the shared FPU.
// The slave modport is the arbiter side and the master modport is the requester/FPU side.
interface fpu_req_arbiter_if;
  logic        req_0;
  logic        req_1;
  logic [31:0] op_a_0;
  logic [31:0] op_b_0;
  logic [31:0] op_a_1;
  logic [31:0] op_b_1;
  logic        gnt_0;
  logic        gnt_1;
  logic        fpu_start;
  logic [31:0] fpu_op_a;
  logic [31:0] fpu_op_b;
  logic        fpu_done;
  logic [31:0] fpu_data_in;
  logic [1:0]  fpu_status_in;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        rsp_timeout;
  logic        busy;

  modport slave (
    input  req_0, req_1, op_a_0, op_b_0, op_a_1, op_b_1,
    input  fpu_done, fpu_data_in, fpu_status_in,
    output gnt_0, gnt_1, fpu_start, fpu_op_a, fpu_op_b,
    output rsp_valid_0, rsp_valid_1, rsp_data, rsp_status, rsp_timeout, busy
  );

  modport master (
    output req_0, req_1, op_a_0, op_b_0, op_a_1, op_b_1,
    output fpu_done, fpu_data_in, fpu_status_in,
    input  gnt_0, gnt_1, fpu_start, fpu_op_a, fpu_op_b,
    input  rsp_valid_0, rsp_valid_1, rsp_data, rsp_status, rsp_timeout, busy
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU between two requesters.
// Defining FPU_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | no transaction; sample requests, capture winner's operands
// ISSUE   | grant pulse to winner plus fpu_start pulse
// WAIT    | waiting for fpu_done (or watchdog expiry)
// RESPOND | rsp_valid pulse to the served requester
module fpu_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clock_100Khz,
  input logic              reset,
  fpu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t      state, state_nxt;
  logic        ptr, ptr_nxt;
  logic        served, served_nxt;
  logic        win;
  logic [31:0] op_a_q, op_a_nxt;
  logic [31:0] op_b_q, op_b_nxt;
  logic [31:0] rsp_data_q, rsp_data_nxt;
  logic [1:0]  rsp_status_q, rsp_status_nxt;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       rsp_timeout_q, rsp_timeout_nxt;
`endif

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      served       <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'd0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      served       <= served_nxt;
      op_a_q       <= op_a_nxt;
      op_b_q       <= op_b_nxt;
      rsp_data_q   <= rsp_data_nxt;
      rsp_status_q <= rsp_status_nxt;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt      <= wait_cnt_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    served_nxt     = served;
    win            = 1'b0;
    op_a_nxt       = op_a_q;
    op_b_nxt       = op_b_q;
    rsp_data_nxt   = rsp_data_q;
    rsp_status_nxt = rsp_status_q;
`ifdef FPU_ARB_TIMEOUT_EN
    wait_cnt_nxt    = wait_cnt;
    rsp_timeout_nxt = rsp_timeout_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req_0 || bus.req_1) begin
          // lone requester wins; on a tie the pointer decides
          win        = (bus.req_0 && bus.req_1) ? ptr : bus.req_1;
          served_nxt = win;
          ptr_nxt    = ~win;
          op_a_nxt   = win ? bus.op_a_1 : bus.op_a_0;
          op_b_nxt   = win ? bus.op_b_1 : bus.op_b_0;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      WAIT: begin
        if (bus.fpu_done) begin
          rsp_data_nxt   = bus.fpu_data_in;
          rsp_status_nxt = bus.fpu_status_in;
          state_nxt      = RESPOND;
`ifdef FPU_ARB_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_data_nxt    = 32'h0;
          rsp_status_nxt  = 2'd3;
          rsp_timeout_nxt = 1'b1;
          state_nxt       = RESPOND;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
`endif
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.fpu_start   = (state == ISSUE);
  assign bus.gnt_0       = (state == ISSUE) && !served;
  assign bus.gnt_1       = (state == ISSUE) &&  served;
  assign bus.rsp_valid_0 = (state == RESPOND) && !served;
  assign bus.rsp_valid_1 = (state == RESPOND) &&  served;
  assign bus.fpu_op_a    = op_a_q;
  assign bus.fpu_op_b    = op_b_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_status  = rsp_status_q;
`ifdef FPU_ARB_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  // constant 0 for every legal TIMEOUT_CYCLES
  assign bus.rsp_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Self-checking bench for fpu_req_arbiter: directed scenarios plus a randomized
// run checked against a transaction-timeline model.
module tb_fpu_req_arbiter;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif
  localparam int RN = 600;
  localparam int RS = RN + 80;

  logic clock_100Khz = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fpu_req_arbiter_if bus();

  fpu_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock_100Khz(clock_100Khz),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  task automatic drive_idle();
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.op_a_0 = '0; bus.op_b_0 = '0; bus.op_a_1 = '0; bus.op_b_1 = '0;
    bus.fpu_done = 1'b0; bus.fpu_data_in = '0; bus.fpu_status_in = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clock_100Khz);
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock_100Khz);
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int who, output int n);
    who = -1; n = 0;
    while (who < 0 && n < 40) begin
      @(negedge clock_100Khz);
      n++;
      if (bus.gnt_0) who = 0;
      else if (bus.gnt_1) who = 1;
    end
  endtask

  task automatic wait_rsp(output int who, output int n);
    who = -1; n = 0;
    while (who < 0 && n < 300) begin
      @(negedge clock_100Khz);
      n++;
      if (bus.rsp_valid_0) who = 0;
      else if (bus.rsp_valid_1) who = 1;
    end
  endtask

  // called at the ISSUE cycle; returns at the expected RESPOND cycle
  task automatic fpu_reply(input int dly, input logic [31:0] res, input logic [1:0] st);
    repeat (dly) @(negedge clock_100Khz);
    bus.fpu_done = 1'b1; bus.fpu_data_in = res; bus.fpu_status_in = st;
    @(negedge clock_100Khz);
    bus.fpu_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock_100Khz);
    drive_idle();
    reset = 1'b1;
    bus.req_0 = 1'b1; bus.fpu_done = 1'b1;
    repeat (3) @(negedge clock_100Khz);
    checks++;
    if ({bus.busy, bus.gnt_1, bus.gnt_0, bus.fpu_start, bus.rsp_valid_1, bus.rsp_valid_0, bus.rsp_timeout} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {bus.busy, bus.gnt_1, bus.gnt_0, bus.fpu_start, bus.rsp_valid_1, bus.rsp_valid_0, bus.rsp_timeout});
    end
    checks++;
    if (bus.rsp_data !== 32'h0 || bus.rsp_status !== 2'd0) begin
      failures++; $display("FAIL reset_rsp got=%h/%0d exp=0/0", bus.rsp_data, bus.rsp_status);
    end
    checks++;
    if (bus.fpu_op_a !== 32'h0 || bus.fpu_op_b !== 32'h0) begin
      failures++; $display("FAIL reset_ops got=%h/%h exp=0/0", bus.fpu_op_a, bus.fpu_op_b);
    end
    drive_idle();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int who, n;
    do_reset();
    bus.req_0 = 1'b1; bus.op_a_0 = 32'h3FE00000; bus.op_b_0 = 32'h3FE00000;
    wait_grant(who, n);
    checks++;
    if (who !== 0 || n !== 1) begin
      failures++; $display("FAIL basic_grant got=%0d@%0d exp=0@1", who, n);
    end
    checks++;
    if (bus.fpu_start !== 1'b1 || bus.fpu_op_a !== 32'h3FE00000 || bus.fpu_op_b !== 32'h3FE00000) begin
      failures++; $display("FAIL basic_issue got=%b %h %h exp=1 3fe00000 3fe00000", bus.fpu_start, bus.fpu_op_a, bus.fpu_op_b);
    end
    bus.req_0 = 1'b0; bus.op_a_0 = 32'hFFFFFFFF;
    @(negedge clock_100Khz);
    checks++;
    if ({bus.gnt_0, bus.gnt_1, bus.fpu_start} !== 3'b000 || bus.busy !== 1'b1 || bus.fpu_op_a !== 32'h3FE00000) begin
      failures++; $display("FAIL basic_wait got=%b busy=%b op=%h exp=000 1 3fe00000",
        {bus.gnt_0, bus.gnt_1, bus.fpu_start}, bus.busy, bus.fpu_op_a);
    end
    repeat (3) @(negedge clock_100Khz);
    @(negedge clock_100Khz);
    bus.fpu_done = 1'b1; bus.fpu_data_in = 32'h40000000; bus.fpu_status_in = 2'd2;
    @(negedge clock_100Khz);
    bus.fpu_done = 1'b0; bus.fpu_data_in = 32'h12345678;
    checks++;
    if ({bus.rsp_valid_1, bus.rsp_valid_0} !== 2'b01 || bus.rsp_data !== 32'h40000000 ||
        bus.rsp_status !== 2'd2 || bus.rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL basic_rsp got=%b %h %0d %b exp=01 40000000 2 0",
        {bus.rsp_valid_1, bus.rsp_valid_0}, bus.rsp_data, bus.rsp_status, bus.rsp_timeout);
    end
    @(negedge clock_100Khz);
    checks++;
    if (bus.rsp_valid_0 !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 32'h40000000) begin
      failures++; $display("FAIL basic_after got=%b %b %h exp=0 0 40000000", bus.rsp_valid_0, bus.busy, bus.rsp_data);
    end
  endtask

  task automatic test_simultaneous();
    int who, n;
    do_reset();
    bus.req_0 = 1'b1; bus.op_a_0 = 32'hA0A0A0A0; bus.op_b_0 = 32'hA1A1A1A1;
    bus.req_1 = 1'b1; bus.op_a_1 = 32'hB0B0B0B0; bus.op_b_1 = 32'hB1B1B1B1;
    wait_grant(who, n);
    checks++;
    if (who !== 0 || bus.fpu_op_a !== 32'hA0A0A0A0 || bus.fpu_op_b !== 32'hA1A1A1A1) begin
      failures++; $display("FAIL sim_first got=%0d %h %h exp=0 a0a0a0a0 a1a1a1a1", who, bus.fpu_op_a, bus.fpu_op_b);
    end
    bus.req_0 = 1'b0;
    fpu_reply(1, 32'h00000011, 2'd3);
    checks++;
    if ({bus.rsp_valid_1, bus.rsp_valid_0} !== 2'b01 || bus.rsp_data !== 32'h11 || bus.rsp_status !== 2'd3) begin
      failures++; $display("FAIL sim_rsp0 got=%b %h %0d exp=01 00000011 3", {bus.rsp_valid_1, bus.rsp_valid_0}, bus.rsp_data, bus.rsp_status);
    end
    wait_grant(who, n);
    checks++;
    if (who !== 1 || n !== 2 || bus.fpu_op_a !== 32'hB0B0B0B0 || bus.fpu_op_b !== 32'hB1B1B1B1) begin
      failures++; $display("FAIL sim_second got=%0d@%0d %h %h exp=1@2 b0b0b0b0 b1b1b1b1", who, n, bus.fpu_op_a, bus.fpu_op_b);
    end
    bus.req_1 = 1'b0;
    fpu_reply(2, 32'h00000022, 2'd1);
    checks++;
    if ({bus.rsp_valid_1, bus.rsp_valid_0} !== 2'b10 || bus.rsp_data !== 32'h22 || bus.rsp_status !== 2'd1) begin
      failures++; $display("FAIL sim_rsp1 got=%b %h %0d exp=10 00000022 1", {bus.rsp_valid_1, bus.rsp_valid_0}, bus.rsp_data, bus.rsp_status);
    end
    bus.req_0 = 1'b1; bus.req_1 = 1'b1;
    wait_grant(who, n);
    checks++;
    if (who !== 0) begin
      failures++; $display("FAIL sim_third got=%0d exp=0", who);
    end
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    fpu_reply(1, 32'h0, 2'd0);
  endtask

  task automatic test_alternate();
    int who, n, rw;
    int exp_seq[4] = '{1, 0, 1, 0};
    do_reset();
    bus.req_1 = 1'b1; bus.op_a_1 = 32'h11110000; bus.op_b_1 = 32'h11110001;
    bus.op_a_0 = 32'h00000F00; bus.op_b_0 = 32'h00000F01;
    for (int i = 0; i < 4; i++) begin
      wait_grant(who, n);
      checks++;
      if (who !== exp_seq[i]) begin
        failures++; $display("FAIL alt_grant%0d got=%0d exp=%0d", i, who, exp_seq[i]);
      end
      bus.req_0 = (who == 1);
      fpu_reply(int'($urandom_range(1, 3)), 32'h0, 2'd2);
      rw = bus.rsp_valid_1 ? 1 : (bus.rsp_valid_0 ? 0 : -1);
      checks++;
      if (rw !== who) begin
        failures++; $display("FAIL alt_rsp%0d got=%0d exp=%0d", i, rw, who);
      end
    end
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    wait_grant(who, n);
    if (who >= 0) fpu_reply(1, 32'h0, 2'd0);
  endtask

  task automatic test_reset_in_wait();
    int who, n;
    bit saw_rsp;
    do_reset();
    bus.req_1 = 1'b1; bus.op_a_1 = 32'hCAFE0001; bus.op_b_1 = 32'hCAFE0002;
    wait_grant(who, n);
    bus.req_1 = 1'b0;
    repeat (2) @(negedge clock_100Khz);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.fpu_op_a !== 32'h0) begin
      failures++; $display("FAIL rstwait_async got=busy%b op=%h exp=busy0 op0", bus.busy, bus.fpu_op_a);
    end
    saw_rsp = 1'b0;
    repeat (2) begin
      @(negedge clock_100Khz);
      if (bus.rsp_valid_0 || bus.rsp_valid_1) saw_rsp = 1'b1;
    end
    bus.fpu_done = 1'b1; bus.fpu_data_in = 32'h0BAD0BAD;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock_100Khz);
      if (bus.rsp_valid_0 || bus.rsp_valid_1 || bus.busy) saw_rsp = 1'b1;
    end
    bus.fpu_done = 1'b0;
    checks++;
    if (saw_rsp !== 1'b0) begin
      failures++; $display("FAIL rstwait_norsp got=%b exp=0", saw_rsp);
    end
    bus.req_1 = 1'b1; bus.op_a_1 = 32'h5EED0001; bus.op_b_1 = 32'h5EED0002;
    wait_grant(who, n);
    checks++;
    if (who !== 1 || bus.fpu_op_b !== 32'h5EED0002) begin
      failures++; $display("FAIL rstwait_regrant got=%0d %h exp=1 5eed0002", who, bus.fpu_op_b);
    end
    bus.req_1 = 1'b0;
    fpu_reply(3, 32'h77777777, 2'd2);
    checks++;
    if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_data !== 32'h77777777 || bus.rsp_status !== 2'd2) begin
      failures++; $display("FAIL rstwait_rsp got=%b %h %0d exp=1 77777777 2", bus.rsp_valid_1, bus.rsp_data, bus.rsp_status);
    end
  endtask

  task automatic test_done_in_idle();
    logic [31:0] prev;
    bit bad;
    @(negedge clock_100Khz);
    prev = bus.rsp_data;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.fpu_done = 1'b1; bus.fpu_data_in = 32'hDEAD0000 + 32'(i); bus.fpu_status_in = 2'd1;
      @(negedge clock_100Khz);
      if (bus.busy || bus.rsp_valid_0 || bus.rsp_valid_1 || bus.fpu_start) bad = 1'b1;
    end
    bus.fpu_done = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL idle_done_activity got=%b exp=0", bad);
    end
    checks++;
    if (bus.rsp_data !== prev || bus.rsp_status !== 2'd2) begin
      failures++; $display("FAIL idle_done_hold got=%h/%0d exp=%h/2", bus.rsp_data, bus.rsp_status, prev);
    end
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int who, n, rw, rn;
    do_reset();
    bus.req_0 = 1'b1; bus.op_a_0 = 32'h1; bus.op_b_0 = 32'h2;
    wait_grant(who, n);
    bus.req_0 = 1'b0;
    wait_rsp(rw, rn);
    checks++;
    if (rw !== 0 || rn !== TO + 1) begin
      failures++; $display("FAIL to_latency got=%0d@%0d exp=0@%0d", rw, rn, TO + 1);
    end
    checks++;
    if (bus.rsp_timeout !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_status !== 2'd3) begin
      failures++; $display("FAIL to_rsp got=%b %h %0d exp=1 0 3", bus.rsp_timeout, bus.rsp_data, bus.rsp_status);
    end
    bus.fpu_done = 1'b1; bus.fpu_data_in = 32'h1234ABCD; bus.fpu_status_in = 2'd0;
    repeat (2) @(negedge clock_100Khz);
    bus.fpu_done = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid_0 !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_timeout !== 1'b1) begin
      failures++; $display("FAIL to_late_done got=%b %b %h %b exp=0 0 0 1", bus.busy, bus.rsp_valid_0, bus.rsp_data, bus.rsp_timeout);
    end
    bus.req_1 = 1'b1;
    wait_grant(who, n);
    bus.req_1 = 1'b0;
    fpu_reply(TO, 32'h0000ABCD, 2'd2);
    checks++;
    if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_data !== 32'h0000ABCD) begin
      failures++; $display("FAIL to_edge_normal got=%b %b %h exp=1 0 0000abcd", bus.rsp_valid_1, bus.rsp_timeout, bus.rsp_data);
    end
  endtask
`else
  task automatic test_long_wait();
    int who, n;
    do_reset();
    bus.req_0 = 1'b1; bus.op_a_0 = 32'h3; bus.op_b_0 = 32'h4;
    wait_grant(who, n);
    bus.req_0 = 1'b0;
    fpu_reply(TO + 20, 32'h0F0F0F0F, 2'd3);
    checks++;
    if (bus.rsp_valid_0 !== 1'b1 || bus.rsp_timeout !== 1'b0 || bus.rsp_data !== 32'h0F0F0F0F) begin
      failures++; $display("FAIL long_wait got=%b %b %h exp=1 0 0f0f0f0f", bus.rsp_valid_0, bus.rsp_timeout, bus.rsp_data);
    end
  endtask
`endif

  // Timeline model: a grant at cycle g with FPU delay d gives done at g+d,
  // response at g+d+1 and the next arbitration opportunity at g+d+2.
  task automatic test_random();
    int          exp_g[RS];
    int          exp_r[RS];
    bit          done_at[RS];
    logic [31:0] res_at[RS], ea[RS], eb[RS], rd_at[RS];
    logic [1:0]  st_at[RS], rs_at[RS];
    logic        rt_at[RS];
    logic [31:0] pa[2], pb[2];
    bit          pend[2];
    int          free_c, ptr, w, g, d;
    logic [31:0] hold_d;
    logic [1:0]  hold_s, eg, er;
    logic        hold_t;
    for (int i = 0; i < RS; i++) begin
      exp_g[i] = -1; exp_r[i] = -1; done_at[i] = 1'b0;
    end
    do_reset();
    free_c = 0; ptr = 0; hold_d = '0; hold_s = 2'd0; hold_t = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < RN; c++) begin
      eg = (exp_g[c] < 0) ? 2'b00 : ((exp_g[c] == 0) ? 2'b01 : 2'b10);
      er = (exp_r[c] < 0) ? 2'b00 : ((exp_r[c] == 0) ? 2'b01 : 2'b10);
      if (exp_r[c] >= 0) begin
        hold_d = rd_at[c]; hold_s = rs_at[c]; hold_t = rt_at[c];
      end
      checks++;
      if ({bus.gnt_1, bus.gnt_0, bus.fpu_start} !== {eg, eg != 2'b00}) begin
        failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {bus.gnt_1, bus.gnt_0, bus.fpu_start}, {eg, eg != 2'b00});
      end
      checks++;
      if ({bus.rsp_valid_1, bus.rsp_valid_0} !== er || bus.busy !== (c != free_c)) begin
        failures++; $display("FAIL rnd_rsp c=%0d got=%b busy=%b exp=%b busy=%b", c,
          {bus.rsp_valid_1, bus.rsp_valid_0}, bus.busy, er, (c != free_c));
      end
      checks++;
      if (bus.rsp_data !== hold_d || bus.rsp_status !== hold_s || bus.rsp_timeout !== hold_t) begin
        failures++; $display("FAIL rnd_data c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c,
          bus.rsp_data, bus.rsp_status, bus.rsp_timeout, hold_d, hold_s, hold_t);
      end
      if (exp_g[c] >= 0) begin
        checks++;
        if (bus.fpu_op_a !== ea[c] || bus.fpu_op_b !== eb[c]) begin
          failures++; $display("FAIL rnd_ops c=%0d got=%h/%h exp=%h/%h", c, bus.fpu_op_a, bus.fpu_op_b, ea[c], eb[c]);
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (exp_g[c] == n) begin
          pend[n] = ($urandom_range(0, 3) == 0);
        end else if (pend[n] && $urandom_range(0, 15) == 0) begin
          pend[n] = 1'b0;
        end else if (!pend[n] && $urandom_range(0, 3) == 0) begin
          pend[n] = 1'b1; pa[n] = $urandom; pb[n] = $urandom;
        end
      end
      bus.req_0 = pend[0]; bus.req_1 = pend[1];
      bus.op_a_0 = pend[0] ? pa[0] : $urandom; bus.op_b_0 = pend[0] ? pb[0] : $urandom;
      bus.op_a_1 = pend[1] ? pa[1] : $urandom; bus.op_b_1 = pend[1] ? pb[1] : $urandom;
      if (done_at[c]) begin
        bus.fpu_done = 1'b1; bus.fpu_data_in = res_at[c]; bus.fpu_status_in = st_at[c];
      end else begin
        bus.fpu_done = ((c == free_c) || exp_g[c] >= 0 || exp_r[c] >= 0) && ($urandom_range(0, 4) == 0);
        bus.fpu_data_in = $urandom; bus.fpu_status_in = 2'($urandom_range(0, 3));
      end
      if (c == free_c) begin
        if (pend[0] || pend[1]) begin
          w = (pend[0] && pend[1]) ? ptr : (pend[1] ? 1 : 0);
          ptr = 1 - w;
          g = c + 1;
          d = int'($urandom_range(1, 6));
          exp_g[g] = w; ea[g] = pa[w]; eb[g] = pb[w];
          if (d > TO) begin
            exp_r[g + TO + 1] = w; rd_at[g + TO + 1] = 32'h0; rs_at[g + TO + 1] = 2'd3; rt_at[g + TO + 1] = 1'b1;
            free_c = g + TO + 2;
          end else begin
            done_at[g + d] = 1'b1; res_at[g + d] = $urandom; st_at[g + d] = 2'($urandom_range(0, 3));
            exp_r[g + d + 1] = w; rd_at[g + d + 1] = res_at[g + d];
            rs_at[g + d + 1] = st_at[g + d]; rt_at[g + d + 1] = 1'b0;
            free_c = g + d + 2;
          end
        end else begin
          free_c = c + 1;
        end
      end
      @(negedge clock_100Khz);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_simultaneous();
    test_alternate();
    test_reset_in_wait();
    test_done_in_idle();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
